sdram_host_bist: RTL and testbench
==================================

// Module: sdram_host_bist
// PURPOSE
//  Synthesizable host-side initiator for the sdram_mcb user interface; replaces the sim-only host.
//  On start: loads a write job, streams a generated pattern into the write FIFO, waits wr_done.
//  Then loads a read job of the same span, drains the read FIFO and checks every word against the
//  regenerated pattern. Reports pass/fail, error count and first failure on board.
//  Clock/data side of sdram_mcb: clk_wr = clk_rd = this block's clk.
// PARAMETERS
//  DATA_W    16          data word width (matches din/dout)
//  ADDR_W    24          {Bank[1:0],Row[12:0],Col[8:0]} word address width
//  LFSR_SEED 16'hACE1    LFSR start value; must be nonzero
//  TIMEOUT   1048576     clk cycles without progress before abort (progress = word moved or done seen)
// PORTS
//  clk            in   1       host clock (50MHz)
//  rst_n          in   1       async active-low reset
//  start          in   1       1-cycle pulse; ignored while busy
//  base_addr      in   ADDR_W  first word address, sampled on start
//  length         in   ADDR_W  word count (1-based), sampled on start
//  pattern_sel    in   1       0: data=addr[15:0] (base+i); 1: LFSR, sampled on start
//  busy           out  1       high from cycle after start until done
//  done           out  1       1-cycle pulse at end of test (pass, fail or timeout)
//  pass           out  1       valid with done, held until next start: err_cnt==0 && !timeout && !proto_err
//  timeout        out  1       sticky until next start
//  proto_err      out  1       sticky: wr_overrun or rd_underrun seen while busy
//  err_cnt        out  16      mismatches, saturates at 16'hFFFF
//  first_err_addr out  ADDR_W  address of first mismatch
//  first_err_data out  DATA_W  dout value at first mismatch
//  wr_load/wr_addr/wr_length/wr_req/din      out  to sdram_mcb write port
//  wr_done/wr_rdy/wr_overrun                 in   from sdram_mcb
//  rd_load/rd_addr/rd_length/rd_req          out  to sdram_mcb read port
//  dout[DATA_W]/rd_done/rd_fifo_cnt[10]/rd_fifo_empty/rd_underrun  in  from sdram_mcb
// BEHAVIOUR
//  Reset: all outputs 0, wr_addr/rd_addr/lengths 0, FSM IDLE. Reset mid-test: requests drop at once.
//  FSM: IDLE -start-> WR_LOAD (wr_load=1 one cycle; wr_addr=base, wr_length=length)
//   -> WR_DATA: wr_req=1 only in cycles where wr_rdy=1 and issued<length; din valid same cycle
//      as wr_req; one word per asserted cycle; leave when issued==length (wr_req deasserted)
//   -> WR_WAIT until wr_done=1 -> RD_LOAD (rd_load=1 one cycle; same addr/length)
//   -> RD_DATA: rd_req=1 when rd_fifo_empty=0 and requested<length; dout valid the cycle AFTER
//      rd_req; compare registered; leave when checked==length -> FIN (done=1) -> IDLE.
//  length==0 at start: no SDRAM traffic, go straight to FIN with pass=1.
//  Pattern: word i expected = pattern_sel ? LFSR_i : (base_addr+i)[15:0]. LFSR x^16+x^14+x^13+x^11+1,
//   Galois, seeded LFSR_SEED at WR_LOAD and re-seeded at RD_LOAD; advances once per word.
//  Address arithmetic base_addr+i is modulo 2^ADDR_W (wraps, no error).
//  Mismatch: err_cnt+=1 (saturating); first_err_* captured only when err_cnt==0.
//  Watchdog: counter cleared on any wr_req/rd_req beat, wr_done or rd_done; reaching TIMEOUT in
//   WR_DATA/WR_WAIT/RD_DATA -> drop requests, timeout=1, go FIN (pass=0).
//  start while busy: ignored. start in FIN cycle: ignored. Status cleared on accepted start.
// TESTING
//  1 base=0x1F0,len=1024,sel=0 -> 1024 wr_req beats din=0x01F0..0x05EF, done, pass=1, err_cnt=0
//  2 base=0x1F1,len=0x100,sel=1, wr_rdy toggled 1-of-3 -> wr_req only when wr_rdy, pass=1
//  3 model flips bit0 of word 5 of case 1 -> err_cnt=1, first_err_addr=0x1F5, first_err_data=0x01F4
//  4 len=0 -> done 2 cycles after start, pass=1, no wr_load/rd_load
//  5 model never asserts wr_done, TIMEOUT=64 -> done, timeout=1, pass=0, no rd_load issued
//  6 rst_n low mid RD_DATA, then start len=16 base=0xFFFFF8 -> clean restart, addr wraps, pass=1

Source files
------------

// File: rtl/sdram_host_bist_if.sv
// User-side bus between the BIST host and the sdram_mcb write/read ports.
interface sdram_host_bist_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic              wr_load;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_length;
  logic              wr_req;
  logic [DATA_W-1:0] din;
  logic              wr_done;
  logic              wr_rdy;
  logic              wr_overrun;
  logic              rd_load;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_length;
  logic              rd_req;
  logic [DATA_W-1:0] dout;
  logic              rd_done;
  logic [9:0]        rd_fifo_cnt;
  logic              rd_fifo_empty;
  logic              rd_underrun;

  modport master (
    output wr_load, wr_addr, wr_length, wr_req, din,
    output rd_load, rd_addr, rd_length, rd_req,
    input  wr_done, wr_rdy, wr_overrun,
    input  dout, rd_done, rd_fifo_cnt, rd_fifo_empty, rd_underrun
  );

  modport slave (
    input  wr_load, wr_addr, wr_length, wr_req, din,
    input  rd_load, rd_addr, rd_length, rd_req,
    output wr_done, wr_rdy, wr_overrun,
    output dout, rd_done, rd_fifo_cnt, rd_fifo_empty, rd_underrun
  );
endinterface

// File: rtl/sdram_host_bist.sv
// Synthesizable write-then-readback pattern tester driving the sdram_mcb user ports.
module sdram_host_bist #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 24,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          TIMEOUT   = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              proto_err,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  sdram_host_bist_if.master mcb
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_LOAD, WR_DATA, WR_WAIT, RD_LOAD, RD_DATA, FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_r, len_r, issued, requested, checked;
  logic              sel_r, wr_done_seen, vld_p1;
  logic [WD_W-1:0]   wd_cnt;
  logic [15:0]       wr_lfsr, wr_pat, chk_lfsr;
  logic [ADDR_W-1:0] chk_addr;
  logic              wr_fire, rd_fire, progress, wd_expired, mismatch;
  logic [DATA_W-1:0] exp_word;

  // Galois form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Requests are combinational so a beat is only offered when the MCB can take it
  assign wr_fire    = (state == WR_DATA) && mcb.wr_rdy && (issued < len_r);
  assign rd_fire    = (state == RD_DATA) && !mcb.rd_fifo_empty && (requested < len_r);
  assign mcb.wr_req = wr_fire;
  assign mcb.rd_req = rd_fire;
  assign mcb.din    = DATA_W'(sel_r ? wr_lfsr : wr_pat);
  assign exp_word   = DATA_W'(sel_r ? chk_lfsr : chk_addr[15:0]);
  assign mismatch   = (state == RD_DATA) && vld_p1 && (mcb.dout != exp_word);
  assign progress   = wr_fire | rd_fire | mcb.wr_done | mcb.rd_done | vld_p1;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1)) && !progress;

  // Pattern generators: write side advances per accepted beat, check side per returned word
  always_ff @(posedge clk) begin
    if (state == WR_LOAD) begin
      wr_lfsr <= LFSR_SEED;
      wr_pat  <= base_r[15:0];
    end else if (wr_fire) begin
      wr_lfsr <= lfsr_next(wr_lfsr);
      wr_pat  <= wr_pat + 16'd1;
    end
    if (state == RD_LOAD) begin
      chk_lfsr <= LFSR_SEED;
      chk_addr <= base_r;
    end else if ((state == RD_DATA) && vld_p1) begin
      chk_lfsr <= lfsr_next(chk_lfsr);
      chk_addr <= chk_addr + 1'b1;
    end
  end

  // Test sequencer, counters, watchdog and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      proto_err      <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      mcb.wr_load    <= 1'b0;
      mcb.wr_addr    <= '0;
      mcb.wr_length  <= '0;
      mcb.rd_load    <= 1'b0;
      mcb.rd_addr    <= '0;
      mcb.rd_length  <= '0;
      base_r         <= '0;
      len_r          <= '0;
      sel_r          <= 1'b0;
      issued         <= '0;
      requested      <= '0;
      checked        <= '0;
      wr_done_seen   <= 1'b0;
      vld_p1         <= 1'b0;
      wd_cnt         <= '0;
    end else begin
      mcb.wr_load <= 1'b0;
      mcb.rd_load <= 1'b0;
      done        <= 1'b0;
      // dout from the FIFO is valid one cycle after rd_req
      vld_p1      <= rd_fire;
      if (wr_fire) issued    <= issued + 1'b1;
      if (rd_fire) requested <= requested + 1'b1;
      // p1: registered compare of returned word against regenerated pattern
      if ((state == RD_DATA) && vld_p1) begin
        checked <= checked + 1'b1;
        if (mismatch) begin
          if (err_cnt == 16'd0) begin
            first_err_addr <= chk_addr;
            first_err_data <= mcb.dout;
          end
          err_cnt <= sat_inc16(err_cnt);
        end
      end
      if (busy && (mcb.wr_overrun || mcb.rd_underrun)) proto_err <= 1'b1;
      if (((state == WR_DATA) || (state == WR_WAIT) || (state == RD_DATA)) && !progress)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            proto_err      <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            base_r         <= base_addr;
            len_r          <= length;
            sel_r          <= pattern_sel;
            if (length == '0) begin
              state <= FIN;
            end else begin
              mcb.wr_load   <= 1'b1;
              mcb.wr_addr   <= base_addr;
              mcb.wr_length <= length;
              state         <= WR_LOAD;
            end
          end
        end
        WR_LOAD: begin
          issued       <= '0;
          wr_done_seen <= 1'b0;
          state        <= WR_DATA;
        end
        WR_DATA: begin
          if (mcb.wr_done) wr_done_seen <= 1'b1;
          if (wd_expired) begin
            timeout <= 1'b1;
            state   <= FIN;
          end else if (issued == len_r) begin
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (wd_expired) begin
            timeout <= 1'b1;
            state   <= FIN;
          end else if (mcb.wr_done || wr_done_seen) begin
            mcb.rd_load   <= 1'b1;
            mcb.rd_addr   <= base_r;
            mcb.rd_length <= len_r;
            state         <= RD_LOAD;
          end
        end
        RD_LOAD: begin
          requested <= '0;
          checked   <= '0;
          state     <= RD_DATA;
        end
        RD_DATA: begin
          if (wd_expired) begin
            timeout <= 1'b1;
            state   <= FIN;
          end else if (checked == len_r) begin
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_cnt == 16'd0) && !timeout && !proto_err;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_host_bist.sv
// Scoreboarded bench for sdram_host_bist with a behavioural sdram_mcb user-port model.
module tb_sdram_host_bist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] base_addr, length;
  logic        pattern_sel;
  logic        busy, done, pass, timeout, proto_err;
  logic [15:0] err_cnt;
  logic [23:0] first_err_addr;
  logic [15:0] first_err_data;

  sdram_host_bist_if #(.DATA_W(16), .ADDR_W(24)) bus ();

  sdram_host_bist #(.DATA_W(16), .ADDR_W(24), .LFSR_SEED(16'hACE1), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .pattern_sel(pattern_sel), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .proto_err(proto_err), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .mcb(bus)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // MCB model controls
  int rdy_mode = 0;
  bit no_wr_done = 1'b0;
  int flip_idx = -1;

  logic [15:0] mem [int];
  logic [15:0] rq [$];
  logic [15:0] exp_q [$];
  logic [23:0] w_addr;
  int w_len, w_idx, wdn, rdy_cnt;
  logic [15:0] word;

  // Monitor statistics
  int wr_beats, rd_beats, din_bad, viol, wrl_cnt, rdl_cnt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Behavioural sdram_mcb: stores written words, returns them through a read FIFO
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.delete();
      wdn = 0; w_idx = 0; rdy_cnt = 0;
      bus.wr_done <= 1'b0; bus.rd_done <= 1'b0; bus.wr_rdy <= 1'b0;
      bus.dout <= '0; bus.rd_fifo_empty <= 1'b1; bus.rd_fifo_cnt <= '0;
    end else begin
      bus.wr_done <= 1'b0;
      bus.rd_done <= 1'b0;
      rdy_cnt++;
      bus.wr_rdy <= (rdy_mode == 0) || (rdy_cnt % 3 == 0);
      if (bus.wr_load) begin
        w_addr = bus.wr_addr; w_len = int'(bus.wr_length); w_idx = 0;
      end
      if (bus.wr_req) begin
        mem[int'(24'(w_addr + 24'(w_idx)))] = bus.din;
        w_idx++;
        if (w_idx == w_len && !no_wr_done) wdn = 4;
      end
      if (wdn > 0) begin
        wdn--;
        if (wdn == 0) bus.wr_done <= 1'b1;
      end
      if (bus.rd_load) begin
        for (int i = 0; i < int'(bus.rd_length); i++) begin
          int a;
          a = int'(24'(bus.rd_addr + 24'(i)));
          word = mem.exists(a) ? mem[a] : 16'h0000;
          if (i == flip_idx) word = word ^ 16'h0001;
          rq.push_back(word);
        end
      end
      if (bus.rd_req && rq.size() > 0) begin
        bus.dout <= rq.pop_front();
        if (rq.size() == 0) bus.rd_done <= 1'b1;
      end
      bus.rd_fifo_empty <= (rq.size() == 0);
      bus.rd_fifo_cnt   <= 10'((rq.size() > 1023) ? 1023 : rq.size());
    end
  end

  // Scoreboard side: pops the expected write word on every wr_req beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_req) begin
        wr_beats++;
        if (!bus.wr_rdy) viol++;
        if (exp_q.size() == 0) din_bad++;
        else if (bus.din !== exp_q.pop_front()) din_bad++;
      end
      if (bus.rd_req) begin
        rd_beats++;
        if (bus.rd_fifo_empty) viol++;
      end
      if (bus.wr_load) wrl_cnt++;
      if (bus.rd_load) rdl_cnt++;
    end
  end

  task automatic do_start(input logic [23:0] b, input logic [23:0] n, input logic s);
    logic [15:0] lf;
    exp_q.delete();
    lf = 16'hACE1;
    for (int i = 0; i < int'(n); i++) begin
      if (s) begin
        exp_q.push_back(lf);
        lf = lfsr_step(lf);
      end else begin
        exp_q.push_back(16'(b + 24'(i)));
      end
    end
    wr_beats = 0; rd_beats = 0; din_bad = 0; viol = 0; wrl_cnt = 0; rdl_cnt = 0;
    @(negedge clk);
    base_addr = b; length = n; pattern_sel = s; start = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit got);
    got = 1'b0; cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1'b1; cyc = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%0b exp=0", pass); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got=%0h exp=0", err_cnt); end
    checks++; if ({bus.wr_req, bus.rd_req, bus.wr_load, bus.rd_load} !== 4'b0) begin
      errors++; $display("FAIL reset_reqs got=%b exp=0000", {bus.wr_req, bus.rd_req, bus.wr_load, bus.rd_load});
    end
    checks++; if (bus.wr_addr !== 24'd0 || bus.rd_length !== 24'd0) begin
      errors++; $display("FAIL reset_addr_len got=%0h/%0h exp=0/0", bus.wr_addr, bus.rd_length);
    end
  endtask

  task automatic test_incr;
    int cyc; bit got;
    do_start(24'h0001F0, 24'd1024, 1'b0);
    wait_done(6000, cyc, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL incr_done got=%0b exp=1", got); end
    checks++; if (wr_beats !== 1024) begin errors++; $display("FAIL incr_wr_beats got=%0d exp=1024", wr_beats); end
    checks++; if (din_bad !== 0) begin errors++; $display("FAIL incr_din got=%0d bad exp=0", din_bad); end
    checks++; if (rd_beats !== 1024) begin errors++; $display("FAIL incr_rd_beats got=%0d exp=1024", rd_beats); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL incr_pass got=%0b exp=1", pass); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL incr_err_cnt got=%0h exp=0", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL incr_busy got=%0b exp=0", busy); end
    checks++; if (wrl_cnt !== 1 || rdl_cnt !== 1) begin
      errors++; $display("FAIL incr_loads got=%0d/%0d exp=1/1", wrl_cnt, rdl_cnt);
    end
  endtask

  task automatic test_lfsr_throttle;
    int cyc; bit got;
    rdy_mode = 1;
    do_start(24'h0001F1, 24'h000100, 1'b1);
    wait_done(4000, cyc, got);
    rdy_mode = 0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL lfsr_done got=%0b exp=1", got); end
    checks++; if (wr_beats !== 256) begin errors++; $display("FAIL lfsr_wr_beats got=%0d exp=256", wr_beats); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL lfsr_req_without_rdy got=%0d exp=0", viol); end
    checks++; if (din_bad !== 0) begin errors++; $display("FAIL lfsr_din got=%0d bad exp=0", din_bad); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL lfsr_pass got=%0b exp=1", pass); end
  endtask

  task automatic test_mismatch;
    int cyc; bit got;
    flip_idx = 5;
    do_start(24'h0001F0, 24'd1024, 1'b0);
    wait_done(6000, cyc, got);
    flip_idx = -1;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mism_done got=%0b exp=1", got); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL mism_err_cnt got=%0h exp=1", err_cnt); end
    checks++; if (first_err_addr !== 24'h0001F5) begin
      errors++; $display("FAIL mism_addr got=%0h exp=1f5", first_err_addr);
    end
    checks++; if (first_err_data !== 16'h01F4) begin
      errors++; $display("FAIL mism_data got=%0h exp=1f4", first_err_data);
    end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mism_pass got=%0b exp=0", pass); end
  endtask

  task automatic test_zero_len;
    int cyc; bit got;
    do_start(24'h000123, 24'd0, 1'b0);
    wait_done(20, cyc, got);
    checks++; if (got !== 1'b1 || cyc !== 2) begin
      errors++; $display("FAIL zero_done_latency got=%0b/%0d exp=1/2", got, cyc);
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass got=%0b exp=1", pass); end
    checks++; if (wrl_cnt !== 0 || rdl_cnt !== 0 || wr_beats !== 0) begin
      errors++; $display("FAIL zero_traffic got=%0d/%0d/%0d exp=0/0/0", wrl_cnt, rdl_cnt, wr_beats);
    end
  endtask

  task automatic test_timeout;
    int cyc; bit got;
    no_wr_done = 1'b1;
    do_start(24'h000040, 24'd8, 1'b0);
    wait_done(400, cyc, got);
    no_wr_done = 1'b0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_done got=%0b exp=1", got); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag got=%0b exp=1", timeout); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL to_pass got=%0b exp=0", pass); end
    checks++; if (rdl_cnt !== 0 || wr_beats !== 8) begin
      errors++; $display("FAIL to_traffic rd_load=%0d wr_beats=%0d exp=0/8", rdl_cnt, wr_beats);
    end
  endtask

  task automatic test_reset_restart;
    int cyc; bit got; bit seen;
    do_start(24'h000100, 24'd64, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.rd_req) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_reach_rd got=%0b exp=1", seen); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, bus.rd_req, bus.wr_req} !== 3'b000) begin
      errors++; $display("FAIL rst_drop got=%b exp=000", {busy, bus.rd_req, bus.wr_req});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(24'hFFFFF8, 24'd16, 1'b0);
    wait_done(400, cyc, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wrap_done got=%0b exp=1", got); end
    checks++; if (wr_beats !== 16 || din_bad !== 0) begin
      errors++; $display("FAIL wrap_din beats=%0d bad=%0d exp=16/0", wr_beats, din_bad);
    end
    checks++; if (pass !== 1'b1 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL wrap_pass got=%0b/%0h exp=1/0", pass, err_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit got;
    do_start(24'h000300, 24'd32, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    base_addr = 24'h000777; length = 24'd5; pattern_sel = 1'b0; start = 1'b1;
    wait_done(1000, cyc, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_done got=%0b exp=1", got); end
    checks++; if (wr_beats !== 32 || din_bad !== 0 || wrl_cnt !== 1) begin
      errors++; $display("FAIL b2b_ignore beats=%0d bad=%0d loads=%0d exp=32/0/1", wr_beats, din_bad, wrl_cnt);
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass got=%0b exp=1", pass); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; pattern_sel = 1'b0;
    bus.wr_overrun = 1'b0; bus.rd_underrun = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_incr;
    test_lfsr_throttle;
    test_mismatch;
    test_zero_len;
    test_timeout;
    test_reset_restart;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
